// File: rtl/riscv_pkg.sv
// riscv_pkg - shared register-index types and forwarding-select encodings.
// Revision 1.0
`default_nettype none

package riscv_pkg;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [1:0] FWD_MEM_WB = 2'b11;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// reg_scoreboard - per-register pending bits for multi-cycle MDU writes.
// Revision 1.0
`default_nettype none

module reg_scoreboard #(
  parameter int m = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [m-1:0]    set_idx,
  input  logic            clr_en,
  input  logic [m-1:0]    clr_idx,
  input  logic [m-1:0]    rs1_idx,
  input  logic [m-1:0]    rs2_idx,
  input  logic [m-1:0]    rd_idx,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            busy_rd,
  output logic [2**m-1:0] busy_vec
);
  localparam int DEPTH = 2**m;

  logic [DEPTH-1:0] bits;

  // Set is evaluated before clear so a same-index issue keeps the bit; x0 never tracks.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (set_en && set_idx == m'(i))
          bits[i] <= 1'b1;
        else if (clr_en && clr_idx == m'(i))
          bits[i] <= 1'b0;
      end
      bits[0] <= 1'b0;
    end
  end

  assign busy_rs1 = bits[rs1_idx];
  assign busy_rs2 = bits[rs2_idx];
  assign busy_rd  = bits[rd_idx];
  assign busy_vec = bits;
endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard - ID-stage stall/bubble generation for load-use and MDU hazards.
// Revision 1.0
`default_nettype none

module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int n         = 32,
  parameter int m         = 5,
  parameter int MAX_STALL = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [m-1:0]    id_rs1,
  input  logic [m-1:0]    id_rs2,
  input  logic [m-1:0]    id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic            id_reg_write,
  input  logic            id_is_mdu,
  input  logic            ID_EX_MemRead,
  input  logic [m-1:0]    ID_EX_rd,
  input  logic            mdu_busy,
  input  logic            mdu_done,
  input  logic [m-1:0]    mdu_done_rd,
  input  logic            flush,
  output logic            stall,
  output logic            id_ex_bubble,
  output logic [2**m-1:0] busy_vec,
  output logic [n-1:0]    stall_count,
  output logic            hazard_timeout
);
  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [m-1:0] ZERO = m'(REG_ZERO);

  logic busy_rs1, busy_rs2, busy_rd;
  logic load_use, raw_sb, waw_sb, struct_haz;
  logic mdu_issue, mdu_clear;
  logic [RUN_W-1:0] run_count;

  reg_scoreboard #(.m(m)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (mdu_issue),
    .set_idx  (id_rd),
    .clr_en   (mdu_clear),
    .clr_idx  (mdu_done_rd),
    .rs1_idx  (id_rs1),
    .rs2_idx  (id_rs2),
    .rd_idx   (id_rd),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rd  (busy_rd),
    .busy_vec (busy_vec)
  );

  assign load_use = ID_EX_MemRead && (ID_EX_rd != ZERO) &&
                    ((id_uses_rs1 && id_rs1 == ID_EX_rd) ||
                     (id_uses_rs2 && id_rs2 == ID_EX_rd));

  // A completing MDU op is visible through MEM_WB, so its register is no longer a hazard.
  assign raw_sb = (id_uses_rs1 && busy_rs1 && !(mdu_done && mdu_done_rd == id_rs1)) ||
                  (id_uses_rs2 && busy_rs2 && !(mdu_done && mdu_done_rd == id_rs2));
  assign waw_sb = id_reg_write && (id_rd != ZERO) && busy_rd &&
                  !(mdu_done && mdu_done_rd == id_rd);
  assign struct_haz = id_is_mdu && mdu_busy;

  assign stall = !rst && id_valid && !flush &&
                 (load_use || raw_sb || waw_sb || struct_haz);
  assign id_ex_bubble = !rst && (stall || flush);

  assign mdu_issue = id_valid && id_is_mdu && id_reg_write && !stall && !flush &&
                     (id_rd != ZERO);
  assign mdu_clear = mdu_done && (mdu_done_rd != ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count    <= '0;
      run_count      <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      if (stall && stall_count != {n{1'b1}})
        stall_count <= stall_count + 1'b1;
      if (stall) begin
        if (run_count != RUN_W'(MAX_STALL))
          run_count <= run_count + 1'b1;
        // The edge that brings the run to MAX_STALL also raises the flag.
        if (run_count >= RUN_W'(MAX_STALL - 1))
          hazard_timeout <= 1'b1;
      end else begin
        run_count <= '0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard - randomized + directed scoreboard bench for hazard_scoreboard.
// Revision 1.0
`default_nettype none

module tb_hazard_scoreboard;
  localparam int N  = 8;
  localparam int MX = 64;
  localparam int CMAX = (1 << N) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_mdu;
  logic ID_EX_MemRead, mdu_busy, mdu_done, flush;
  logic [4:0] id_rs1, id_rs2, id_rd, ID_EX_rd, mdu_done_rd;
  logic stall, id_ex_bubble, hazard_timeout;
  logic [31:0] busy_vec;
  logic [N-1:0] stall_count;

  hazard_scoreboard #(.n(N), .m(5), .MAX_STALL(MX)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_is_mdu(id_is_mdu), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_rd(ID_EX_rd), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .mdu_done_rd(mdu_done_rd), .flush(flush), .stall(stall), .id_ex_bubble(id_ex_bubble),
    .busy_vec(busy_vec), .stall_count(stall_count), .hazard_timeout(hazard_timeout)
  );

  typedef struct {
    bit rst, valid, u1, u2, rw, mdu, memrd, mbusy, done, flush;
    bit [4:0] rs1, rs2, rd, exrd, drd;
  } stim_t;

  typedef struct {
    bit st, bub, tmo;
    bit [31:0] bv;
    int cnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference state: pending MDU destinations, stall total, current stall run, flag.
  bit mb[32];
  int m_cnt = 0;
  int m_run = 0;
  bit m_tmo = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit pending(input bit [4:0] idx, input bit uses, input bit done,
                                 input bit [4:0] drd);
    return uses && mb[idx] && !(done && drd == idx);
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit lu, raw, waw, st;
    @(posedge clk);
    #1;
    rst = s.rst; id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_reg_write = s.rw; id_is_mdu = s.mdu;
    ID_EX_MemRead = s.memrd; ID_EX_rd = s.exrd; mdu_busy = s.mbusy;
    mdu_done = s.done; mdu_done_rd = s.drd; flush = s.flush;

    lu  = s.memrd && s.exrd != 0 && ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd));
    raw = pending(s.rs1, s.u1, s.done, s.drd) || pending(s.rs2, s.u2, s.done, s.drd);
    waw = s.rd != 0 && pending(s.rd, s.rw, s.done, s.drd);
    st  = !s.rst && s.valid && !s.flush && (lu || raw || waw || (s.mdu && s.mbusy));
    e.st  = st;
    e.bub = !s.rst && (st || s.flush);
    e.tmo = m_tmo;
    e.cnt = m_cnt;
    for (int i = 0; i < 32; i++) e.bv[i] = mb[i];
    q.push_back(e);

    if (s.rst) begin
      for (int i = 0; i < 32; i++) mb[i] = 0;
      m_cnt = 0; m_run = 0; m_tmo = 0;
    end else begin
      if (s.done && s.drd != 0) mb[s.drd] = 0;
      if (s.valid && s.mdu && s.rw && !st && !s.flush && s.rd != 0) mb[s.rd] = 1;
      if (st) begin
        if (m_cnt < CMAX) m_cnt++;
        m_run++;
        if (m_run >= MX) m_tmo = 1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", {31'b0, stall}, {31'b0, e.st});
        chk("bubble", {31'b0, id_ex_bubble}, {31'b0, e.bub});
        chk("busy_vec", busy_vec, e.bv);
        chk("stall_count", {24'b0, stall_count}, e.cnt);
        chk("timeout", {31'b0, hazard_timeout}, {31'b0, e.tmo});
      end
    end
  end

  function automatic stim_t mdu_issue(input bit [4:0] rd);
    stim_t s;
    s = idle();
    s.valid = 1; s.mdu = 1; s.rw = 1; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t reader(input bit [4:0] r);
    stim_t s;
    s = idle();
    s.valid = 1; s.u1 = 1; s.rs1 = r; s.rw = 1; s.rd = 5'd20;
    return s;
  endfunction

  initial begin
    stim_t s;
    int list[$];
    rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0;
    id_uses_rs2 = 0; id_reg_write = 0; id_is_mdu = 0; ID_EX_MemRead = 0; ID_EX_rd = 0;
    mdu_busy = 0; mdu_done = 0; mdu_done_rd = 0; flush = 0;
    for (int i = 0; i < 32; i++) mb[i] = 0;

    s = idle(); s.rst = 1;
    apply(s); apply(s);
    apply(idle());
    @(negedge clk);
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_count", {24'b0, stall_count}, 32'h0);

    // Load-use: one stall, then the load has moved on.
    s = reader(5'd5); s.memrd = 1; s.exrd = 5'd5;
    apply(s);
    @(negedge clk);
    chk("lu_stall", {31'b0, stall}, 32'h1);
    chk("lu_bubble", {31'b0, id_ex_bubble}, 32'h1);
    apply(reader(5'd5));
    @(negedge clk);
    chk("lu_one_cycle", {31'b0, stall}, 32'h0);
    chk("lu_count", {24'b0, stall_count}, 32'h1);

    // x0 immunity.
    s = idle(); s.valid = 1; s.u2 = 1; s.rs2 = 0; s.memrd = 1; s.exrd = 0;
    s.done = 1; s.drd = 0;
    apply(s);
    @(negedge clk);
    chk("x0_stall", {31'b0, stall}, 32'h0);

    // MDU RAW with completion bypass.
    apply(mdu_issue(5'd7));
    for (int i = 0; i < 3; i++) apply(reader(5'd7));
    s = reader(5'd7); s.done = 1; s.drd = 5'd7;
    apply(s);
    @(negedge clk);
    chk("bypass_stall", {31'b0, stall}, 32'h0);
    apply(idle());
    @(negedge clk);
    chk("x7_cleared", {31'b0, busy_vec[7]}, 32'h0);

    // Same-cycle set/clear, same and different index.
    apply(mdu_issue(5'd9));
    s = mdu_issue(5'd9); s.done = 1; s.drd = 5'd9;
    apply(s);
    apply(mdu_issue(5'd4));
    @(negedge clk);
    chk("set_wins", {31'b0, busy_vec[9]}, 32'h1);
    s = idle(); s.done = 1; s.drd = 5'd9;
    apply(s);
    s = mdu_issue(5'd9); s.done = 1; s.drd = 5'd4;
    apply(s);
    apply(idle());
    @(negedge clk);
    chk("diff_idx", {30'b0, busy_vec[9], busy_vec[4]}, 32'h2);

    // Flush over a stalled MDU instruction.
    s = mdu_issue(5'd11); s.u1 = 1; s.rs1 = 5'd9; s.flush = 1;
    apply(s);
    @(negedge clk);
    chk("flush_stall", {31'b0, stall}, 32'h0);
    chk("flush_bubble", {31'b0, id_ex_bubble}, 32'h1);
    apply(idle());
    @(negedge clk);
    chk("flush_bits", {30'b0, busy_vec[11], busy_vec[9]}, 32'h1);

    // Watchdog, then counter saturation.
    for (int i = 0; i < MX - 1; i++) apply(reader(5'd9));
    @(negedge clk);
    chk("wd_early", {31'b0, hazard_timeout}, 32'h0);
    apply(reader(5'd9));
    apply(reader(5'd9));
    @(negedge clk);
    chk("wd_set", {31'b0, hazard_timeout}, 32'h1);
    s = idle(); s.done = 1; s.drd = 5'd9;
    apply(s);
    apply(mdu_issue(5'd3));
    for (int i = 0; i < 200; i++) apply(reader(5'd3));
    @(negedge clk);
    chk("wd_sticky", {31'b0, hazard_timeout}, 32'h1);
    chk("saturate", {24'b0, stall_count}, CMAX);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) == 0);
      s.valid = ($urandom_range(0, 9) != 0);
      s.rs1 = 5'($urandom_range(0, 11)); s.rs2 = 5'($urandom_range(0, 11));
      s.rd  = 5'($urandom_range(0, 11));
      s.u1 = 1'($urandom); s.u2 = 1'($urandom); s.rw = 1'($urandom);
      s.mdu = ($urandom_range(0, 2) == 0);
      s.memrd = ($urandom_range(0, 3) == 0); s.exrd = 5'($urandom_range(0, 11));
      s.mbusy = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 14) == 0);
      list.delete();
      for (int i = 1; i < 32; i++) if (mb[i]) list.push_back(i);
      if (list.size() > 0 && $urandom_range(0, 3) == 0) begin
        s.done = 1; s.drd = 5'(list[$urandom_range(0, list.size() - 1)]);
      end else if ($urandom_range(0, 29) == 0) begin
        s.done = 1; s.drd = 5'($urandom_range(0, 11));
      end
      apply(s);
    end

    s = idle(); s.rst = 1; s.valid = 1; s.u1 = 1; s.rs1 = 5'd3; s.memrd = 1; s.exrd = 5'd3;
    apply(s);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    apply(idle());
    @(negedge clk);
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_count", {24'b0, stall_count}, 32'h0);
    chk("rst_timeout", {31'b0, hazard_timeout}, 32'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
